// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive definitions: frame width and receiver FSM state encoding.
`timescale 1ns/100ps
package uart_rx_core_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_core_if.sv
// Serial-in / byte-out bundle. master = receiver side, slave = line driver and byte consumer.
`timescale 1ns/100ps
interface uart_rx_core_if;
  import uart_rx_core_pkg::*;
  logic                      in;
  logic [UART_DATA_BITS-1:0] out;
  logic                      valid;
  logic                      framing_error;

  modport master (input in, output out, output valid, output framing_error);
  modport slave  (output in, input out, input valid, input framing_error);
endinterface

// File: rtl/uart_rx_core_bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; resets to RESET_VAL.
`timescale 1ns/100ps
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle valid / framing_error pulses.
`timescale 1ns/100ps
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int RECEIVER_PERIOD = 868
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_core_if.master rx
);
  localparam int CW = $clog2(RECEIVER_PERIOD);
  localparam logic [CW-1:0]         HALF_LAST = CW'(RECEIVER_PERIOD / 2 - 1);
  localparam logic [CW-1:0]         BIT_LAST  = CW'(RECEIVER_PERIOD - 1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST  = UART_IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] out_q;
  logic                      valid_q, fe_q;
  logic                      s, prev;

  bit_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.in),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      prev    <= 1'b1;
      out_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      prev    <= s;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          // Edge, not level: a line stuck low stays parked here.
          if (prev && !s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (s) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {s, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (s) begin
              out_q   <= shift;
              valid_q <= 1'b1;
            end else begin
              fe_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rx.out           = out_q;
  assign rx.valid         = valid_q;
  assign rx.framing_error = fe_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: stimulus pushes expected bytes/errors, per-DUT monitors pop on each output pulse.
`timescale 1ns/100ps
module tb_uart_rx_core;
  import uart_rx_core_pkg::*;

  typedef struct packed {logic fe; logic [7:0] data;} exp_t;

  logic clk, rst;
  uart_rx_core_if ifa();
  uart_rx_core_if ifb();

  uart_rx_core #(.RECEIVER_PERIOD(16)) dut_a (.clk(clk), .rst(rst), .rx(ifa));
  uart_rx_core #(.RECEIVER_PERIOD(5))  dut_b (.clk(clk), .rst(rst), .rx(ifb));

  exp_t       qa[$], qb[$];
  exp_t       ea, eb;
  int         applied = 0, errors = 0;
  logic [7:0] last_a, last_b;
  logic       pa_prev, pb_prev;
  logic [7:0] t2[3] = '{8'hA3, 8'h00, 8'hFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the RECEIVER_PERIOD=16 instance
  always @(negedge clk) begin
    if (rst) begin
      pa_prev = 1'b0;
    end else begin
      if (ifa.valid || ifa.framing_error) begin
        check("a_exclusive", {31'd0, ifa.valid & ifa.framing_error}, 32'd0);
        check("a_no_back_to_back", {31'd0, pa_prev}, 32'd0);
        applied++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_pulse: valid=%0b fe=%0b out=%0h", ifa.valid, ifa.framing_error, ifa.out);
        end else begin
          ea = qa.pop_front();
          check("a_pulse_kind", {31'd0, ifa.framing_error}, {31'd0, ea.fe});
          if (ea.fe) check("a_out_held", {24'd0, ifa.out}, {24'd0, last_a});
          else begin
            check("a_data", {24'd0, ifa.out}, {24'd0, ea.data});
            last_a = ea.data;
          end
        end
      end
      pa_prev = ifa.valid | ifa.framing_error;
    end
  end

  // Monitor for the RECEIVER_PERIOD=5 instance
  always @(negedge clk) begin
    if (rst) begin
      pb_prev = 1'b0;
    end else begin
      if (ifb.valid || ifb.framing_error) begin
        check("b_exclusive", {31'd0, ifb.valid & ifb.framing_error}, 32'd0);
        check("b_no_back_to_back", {31'd0, pb_prev}, 32'd0);
        applied++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_pulse: valid=%0b fe=%0b out=%0h", ifb.valid, ifb.framing_error, ifb.out);
        end else begin
          eb = qb.pop_front();
          check("b_pulse_kind", {31'd0, ifb.framing_error}, {31'd0, eb.fe});
          if (!eb.fe) begin
            check("b_data", {24'd0, ifb.out}, {24'd0, eb.data});
            last_b = eb.data;
          end
        end
      end
      pb_prev = ifb.valid | ifb.framing_error;
    end
  end

  // Ideal 16-clock bits; the line is left at the stop value on return.
  task automatic send_a(input logic [7:0] b, input logic stop);
    ifa.in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ifa.in = b[i];
      repeat (16) @(negedge clk);
    end
    ifa.in = stop;
    repeat (16) @(negedge clk);
  endtask

  // Skewed sender: edges sit at x.5 ns so they never coincide with a clock edge.
  task automatic send_b(input logic [7:0] b, input int bit_ns);
    @(posedge clk);
    #8.5;
    ifb.in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      ifb.in = b[i];
      #(bit_ns);
    end
    ifb.in = 1'b1;
    #(bit_ns);
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    ifa.in = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    ifa.in = 1'b1;
    ifb.in = 1'b1;
    rst    = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_out",   {24'd0, ifa.out}, 32'd0);
    check("reset_valid", {31'd0, ifa.valid}, 32'd0);
    check("reset_fe",    {31'd0, ifa.framing_error}, 32'd0);
    check("reset_state", 32'(dut_a.state), 32'(RX_IDLE));
    check("reset_out_b", {24'd0, ifb.out}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: single frame
    qa.push_back('{fe: 1'b0, data: 8'h55});
    send_a(8'h55, 1'b1);
    repeat (64) @(negedge clk);
    check("t1_drained", qa.size(), 32'd0);
    check("t1_out", {24'd0, ifa.out}, 32'h55);

    // 2: back-to-back frames, no idle gap
    for (int i = 0; i < 3; i++) begin
      qa.push_back('{fe: 1'b0, data: t2[i]});
      send_a(t2[i], 1'b1);
    end
    repeat (64) @(negedge clk);
    check("t2_drained", qa.size(), 32'd0);
    check("t2_out", {24'd0, ifa.out}, 32'hFF);

    // 3: 3-cycle glitch must be rejected at the start-bit midpoint
    ifa.in = 1'b0;
    repeat (3) @(negedge clk);
    ifa.in = 1'b1;
    repeat (9) @(negedge clk);
    check("t3_idle_by_12", 32'(dut_a.state), 32'(RX_IDLE));
    repeat (64) @(negedge clk);
    check("t3_out_kept", {24'd0, ifa.out}, 32'hFF);

    // 4: framing error, stuck-low line, recovery
    do_reset();
    qa.push_back('{fe: 1'b1, data: 8'h00});
    send_a(8'h3C, 1'b0);
    repeat (40 * 16) @(negedge clk);
    check("t4_fe_seen", qa.size(), 32'd0);
    check("t4_out_zero", {24'd0, ifa.out}, 32'h00);
    check("t4_idle_low", 32'(dut_a.state), 32'(RX_IDLE));
    ifa.in = 1'b1;
    repeat (4 * 16) @(negedge clk);
    qa.push_back('{fe: 1'b0, data: 8'h81});
    send_a(8'h81, 1'b1);
    repeat (64) @(negedge clk);
    check("t4_drained", qa.size(), 32'd0);
    check("t4_out", {24'd0, ifa.out}, 32'h81);

    // 5: reset during bit 4 of 0x7E discards the frame
    do_reset();
    ifa.in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ifa.in = t2[0][i] ^ t2[0][i] ^ (8'h7E >> i) & 1'b1;
      repeat (16) @(negedge clk);
    end
    ifa.in = 1'b1;
    repeat (8) @(negedge clk);
    rst    = 1'b1;
    last_a = 8'h00;
    repeat (2) @(negedge clk);
    check("t5_rst_state", 32'(dut_a.state), 32'(RX_IDLE));
    rst = 1'b0;
    repeat (12 * 16) @(negedge clk);
    check("t5_out_zero", {24'd0, ifa.out}, 32'h00);
    qa.push_back('{fe: 1'b0, data: 8'h12});
    send_a(8'h12, 1'b1);
    repeat (64) @(negedge clk);
    check("t5_drained", qa.size(), 32'd0);
    check("t5_out", {24'd0, ifa.out}, 32'h12);

    // 6: RECEIVER_PERIOD=5 with alternating -4% / +4% sender bit time
    for (int i = 0; i < 256; i++) begin
      qb.push_back('{fe: 1'b0, data: 8'(i)});
      send_b(8'(i), (i % 2 == 1) ? 52 : 48);
    end
    repeat (40) @(negedge clk);
    check("t6_drained", qb.size(), 32'd0);
    check("t6_out", {24'd0, ifb.out}, 32'hFF);
    check("t6_a_quiet", qa.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
